// File: rtl/regfile_rd_pkg.sv
// Shared constants and read-port bundle for the register file.
// Build option: REGFILE_BYPASS_EN (same-edge write-to-read forwarding).
package regfile_rd_pkg;

  localparam int WIDTH_D = 8;
  localparam int DEPTH_D = 8;
  localparam int AW_D    = $clog2(DEPTH_D);

  typedef struct packed {
    logic              req;
    logic [AW_D-1:0]   addr;
    logic              ack;
    logic [WIDTH_D-1:0] data;
    logic              dvalid;
    logic              dready;
  } rd_port_t;

  function automatic logic [DEPTH_D-1:0] onehot_d(
    input logic [AW_D-1:0] a
  );
    onehot_d = DEPTH_D'(1) << a;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: source mux (with optional bypass) feeding a
// registered valid/ready output stage. Option: REGFILE_BYPASS_EN.
module regfile_rd_port
  import regfile_rd_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int DEPTH = DEPTH_D,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic                        we,
  input  logic [AW-1:0]               waddr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        req,
  input  logic [AW-1:0]               addr,
  output logic                        ack,
  output logic [WIDTH-1:0]            data,
  output logic                        dvalid,
  input  logic                        dready
);

  logic [WIDTH-1:0] src;
  logic             take;

  always_comb begin
    src = regs[addr];
`ifdef REGFILE_BYPASS_EN
    if (we && waddr == addr) src = wdata;
`endif
    if (addr == '0) src = '0;
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{we, waddr, wdata};
`endif

  // ack depends only on the output stage, never on req
  assign ack  = !dvalid || dready;
  assign take = req && ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data   <= '0;
      dvalid <= 1'b0;
    end else if (take) begin
      data   <= src;
      dvalid <= 1'b1;
    end else if (dvalid && dready) begin
      dvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_rd.sv
// Register file: one write port, two handshaked read ports.
// Option: REGFILE_BYPASS_EN forwards wdata on same-edge collisions.
module regfile_rd
  import regfile_rd_pkg::*;
#(
  parameter int              WIDTH = WIDTH_D,
  parameter int              DEPTH = DEPTH_D,
  parameter int              AW    = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] RVAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ra_req,
  input  logic [AW-1:0]    ra_addr,
  output logic             ra_ack,
  output logic [WIDTH-1:0] ra_data,
  output logic             ra_dvalid,
  input  logic             ra_dready,
  input  logic             rb_req,
  input  logic [AW-1:0]    rb_addr,
  output logic             rb_ack,
  output logic [WIDTH-1:0] rb_data,
  output logic             rb_dvalid,
  input  logic             rb_dready
);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0]            wen;

  always_comb begin
    wen = '0;
    if (we) wen = DEPTH'(1) << waddr;
    wen[0] = 1'b0;
  end

  // entry 0 resets like the rest but is never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= RVAL;
    end else begin
      for (int i = 1; i < DEPTH; i++)
        if (wen[i]) regs[i] <= wdata;
    end
  end

  regfile_rd_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)
  ) u_pa (
    .clk    (clk),
    .reset  (reset),
    .regs   (regs),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .req    (ra_req),
    .addr   (ra_addr),
    .ack    (ra_ack),
    .data   (ra_data),
    .dvalid (ra_dvalid),
    .dready (ra_dready)
  );

  regfile_rd_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)
  ) u_pb (
    .clk    (clk),
    .reset  (reset),
    .regs   (regs),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .req    (rb_req),
    .addr   (rb_addr),
    .ack    (rb_ack),
    .data   (rb_data),
    .dvalid (rb_dvalid),
    .dready (rb_dready)
  );

endmodule

// File: tb/tb_regfile_rd.sv
// Directed bench for regfile_rd with RVAL=8'h5A.
// Honours REGFILE_BYPASS_EN for the same-edge collision case.
module tb_regfile_rd;

  logic       clk = 1'b0;
  logic       reset;
  logic       we;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic       ra_req, rb_req;
  logic [2:0] ra_addr, rb_addr;
  logic       ra_ack, rb_ack;
  logic [7:0] ra_data, rb_data;
  logic       ra_dvalid, rb_dvalid;
  logic       ra_dready, rb_dready;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  regfile_rd #(.WIDTH(8), .DEPTH(8), .RVAL(8'h5A)) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .ra_req    (ra_req),
    .ra_addr   (ra_addr),
    .ra_ack    (ra_ack),
    .ra_data   (ra_data),
    .ra_dvalid (ra_dvalid),
    .ra_dready (ra_dready),
    .rb_req    (rb_req),
    .rb_addr   (rb_addr),
    .rb_ack    (rb_ack),
    .rb_data   (rb_data),
    .rb_dvalid (rb_dvalid),
    .rb_dready (rb_dready)
  );

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] coll_exp;
  logic [2:0] a_seq [3];
  logic [2:0] b_seq [3];
  logic [7:0] a_exp [3];
  logic [7:0] b_exp [3];

  initial begin
`ifdef REGFILE_BYPASS_EN
    coll_exp = 8'h77;
`else
    coll_exp = 8'h11;
`endif
    a_seq = '{3'd1, 3'd2, 3'd3};
    b_seq = '{3'd3, 3'd2, 3'd1};
    a_exp = '{8'h5A, 8'h99, 8'hC3};
    b_exp = '{8'hC3, 8'h99, 8'h5A};

    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    ra_req = 1'b0; ra_addr = '0; ra_dready = 1'b0;
    rb_req = 1'b0; rb_addr = '0; rb_dready = 1'b0;
    #3;
    chk("rst_ra_dvalid", {7'd0, ra_dvalid}, 8'd0);
    chk("rst_ra_data", ra_data, 8'h00);
    chk("rst_rb_dvalid", {7'd0, rb_dvalid}, 8'd0);
    chk("rst_ra_ack", {7'd0, ra_ack}, 8'd1);
    chk("rst_rb_ack", {7'd0, rb_ack}, 8'd1);
    tick();
    reset = 1'b0;

    // RVAL read-out of regs 1..7, then reg 0
    ra_req = 1'b1; ra_dready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      ra_addr = 3'(i);
      #1 chk($sformatf("rval_ack%0d", i), {7'd0, ra_ack}, 8'd1);
      tick();
      chk($sformatf("rval_dv%0d", i), {7'd0, ra_dvalid}, 8'd1);
      chk($sformatf("rval_d%0d", i), ra_data, 8'h5A);
    end
    ra_addr = 3'd0;
    tick();
    chk("r0_data", ra_data, 8'h00);
    chk("r0_dvalid", {7'd0, ra_dvalid}, 8'd1);
    ra_req = 1'b0;
    tick();
    chk("consume_dvalid", {7'd0, ra_dvalid}, 8'd0);
    chk("consume_hold", ra_data, 8'h00);

    // write to reg 0 is ignored
    we = 1'b1; waddr = 3'd0; wdata = 8'hEE;
    tick();
    we = 1'b0; ra_req = 1'b1; ra_addr = 3'd0;
    tick();
    ra_req = 1'b0;
    chk("r0_wr_ignored", ra_data, 8'h00);

    // write on N, read accepted on N+1
    we = 1'b1; waddr = 3'd3; wdata = 8'hC3;
    tick();
    we = 1'b0; ra_req = 1'b1; ra_addr = 3'd3;
    tick();
    ra_req = 1'b0;
    chk("wr_then_rd", ra_data, 8'hC3);
    tick();

    // same-edge collision on port B
    we = 1'b1; waddr = 3'd5; wdata = 8'h11;
    tick();
    wdata = 8'h77; rb_req = 1'b1; rb_addr = 3'd5; rb_dready = 1'b1;
    tick();
    we = 1'b0;
    chk("collide_rb", rb_data, coll_exp);
    tick();
    rb_req = 1'b0;
    chk("after_collide", rb_data, 8'h77);
    tick();

    // backpressure snapshot on port A
    we = 1'b1; waddr = 3'd2; wdata = 8'h22;
    tick();
    we = 1'b0; ra_req = 1'b1; ra_addr = 3'd2; ra_dready = 1'b0;
    tick();
    ra_req = 1'b0;
    we = 1'b1; wdata = 8'h99;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall_ack%0d", i), {7'd0, ra_ack}, 8'd0);
      tick();
      we = 1'b0;
      chk($sformatf("stall_d%0d", i), ra_data, 8'h22);
      chk($sformatf("stall_dv%0d", i), {7'd0, ra_dvalid}, 8'd1);
    end
    ra_dready = 1'b1;
    #1 chk("unstall_ack", {7'd0, ra_ack}, 8'd1);
    tick();
    chk("unstall_dv", {7'd0, ra_dvalid}, 8'd0);
    chk("unstall_hold", ra_data, 8'h22);

    // back-to-back on both ports
    ra_req = 1'b1; rb_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ra_addr = a_seq[i]; rb_addr = b_seq[i];
      #1;
      chk($sformatf("b2b_aack%0d", i), {7'd0, ra_ack}, 8'd1);
      chk($sformatf("b2b_back%0d", i), {7'd0, rb_ack}, 8'd1);
      tick();
      chk($sformatf("b2b_a%0d", i), ra_data, a_exp[i]);
      chk($sformatf("b2b_b%0d", i), rb_data, b_exp[i]);
      chk($sformatf("b2b_adv%0d", i), {7'd0, ra_dvalid}, 8'd1);
    end
    ra_req = 1'b0; rb_req = 1'b0;
    tick();
    chk("b2b_end_adv", {7'd0, ra_dvalid}, 8'd0);
    chk("b2b_end_bdv", {7'd0, rb_dvalid}, 8'd0);

    // reset while a result is pending
    ra_req = 1'b1; ra_addr = 3'd3; ra_dready = 1'b0;
    tick();
    ra_req = 1'b0;
    chk("pre_rst_dv", {7'd0, ra_dvalid}, 8'd1);
    #2 reset = 1'b1;
    #1 chk("async_rst_dv", {7'd0, ra_dvalid}, 8'd0);
    chk("async_rst_d", ra_data, 8'h00);
    tick();
    reset = 1'b0;
    ra_dready = 1'b1; ra_req = 1'b1;
    for (int i = 2; i < 6; i++) begin
      ra_addr = 3'(i);
      tick();
      chk($sformatf("post_rst_r%0d", i), ra_data, 8'h5A);
    end
    ra_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
